siso_arb_tx: RTL
================

// Module: siso_arb_tx
// PURPOSE
//  Two-requester round-robin arbiter and sequencer for a shared serial-out link.
//  Accepts a parallel word from the winning requester, loads it into a shift register,
//  shifts it out MSB-first over WIDTH cycles, then enforces an inter-frame gap.
//  Sits between parallel producers and the serial line driven by the SISO/PISO shift path.
// PARAMETERS
//  WIDTH       8   bits per frame; legal range >= 2
//  GAP_CYCLES  1   forced idle cycles after each frame's last bit; legal range >= 0
// PORTS
//  clk          in   1      system clock, rising edge
//  Rst          in   1      asynchronous, active-low reset
//  req0         in   1      requester 0 has a word; held high with data0 stable until gnt0
//  data0        in   WIDTH  requester 0 word
//  req1         in   1      requester 1 has a word; same rules as req0
//  data1        in   WIDTH  requester 1 word
//  gnt0         out  1      1-cycle pulse: data0 captured
//  gnt1         out  1      1-cycle pulse: data1 captured
//  serial_out   out  1      serial data, MSB first; 0 when not shifting
//  frame_valid  out  1      high on every cycle serial_out carries a data bit
//  frame_last   out  1      high with the final (LSB) bit of a frame
//  src_id       out  1      owner of current frame (0/1); holds last value when idle
//  busy         out  1      high in SHIFT and GAP states
// BEHAVIOUR
//  - All outputs are registered. While Rst=0, every output is 0, state=IDLE, rr_last=1.
//  - FSM states: IDLE, SHIFT, GAP.
//  - IDLE: arbitrate at each rising edge.
//    - Single request: that requester wins.
//    - Both requests: the requester != rr_last wins. After reset, req0 wins first.
//    - On a win at edge k: capture the word, set rr_last and src_id, go to SHIFT.
//    - In cycle k+1: gnt pulse, frame_valid=1, serial_out=data[WIDTH-1].
//  - SHIFT: bit counter runs 0..WIDTH-1; serial_out = data[WIDTH-1-cnt].
//    - frame_last=1 when cnt=WIDTH-1.
//    - Next state is GAP, or IDLE if GAP_CYCLES=0.
//  - GAP: GAP_CYCLES cycles with frame_valid=0, serial_out=0, busy=1, then IDLE.
//  - Requests are ignored outside IDLE. No new grant is issued until IDLE is re-entered.
//  - Minimum spacing between frames: GAP_CYCLES+1 cycles with frame_valid=0.
//  - Latency: request sampled at edge k -> first data bit in cycle k+1. Frame occupies WIDTH cycles.
//  - A requester drops req after seeing gnt. WIDTH >= 2 ensures no double grant.
//  - Reset mid-frame: frame is aborted and outputs clear immediately (asynchronous).
//    No retransmit state is kept; a requester still holding req is re-arbitrated after release.
//  - Counter width is $clog2(WIDTH). The GAP counter is $clog2(GAP_CYCLES+1) bits, minimum 1.
// STRUCTURE
//  - Package siso_ctrl_pkg: typedef enum {IDLE, SHIFT, GAP} tx_state_t; localparam encodings.
//  - Sub-module piso_shifter: ports clk, Rst, load, shift_en, data_in[WIDTH], serial_out.
//    Loads a parallel word and shifts it MSB-first.
//  - Top module holds the FSM, round-robin pointer, bit and gap counters, and grant/status registers.
// TESTING
//  1. Rst=0 mid-run -> all outputs 0 asynchronously. Release with no req -> remains IDLE, busy=0.
//  2. req0=1, data0=8'hA5 ->
//     - gnt0 pulse for 1 cycle;
//     - serial_out 1,0,1,0,0,1,0,1 with frame_valid=1 and src_id=0;
//     - frame_last on the 8th bit; 1 GAP cycle; back to IDLE.
//  3. req0=req1=1 together, data0=8'hFF, data1=8'h00 after reset ->
//     - first frame src_id=0 (all 1s);
//     - 2 cycles with frame_valid=0;
//     - second frame src_id=1 (all 0s).
//  4. req0 and req1 re-asserted continuously for 4 frames -> src_id sequence 0,1,0,1; exactly one gnt per frame.
//  5. Rst=0 during bit 3 of a req1 frame, then release with req0 and req1 high ->
//     - truncated frame, no frame_last;
//     - next frame src_id=0, starting from bit 0.
//  6. GAP_CYCLES=0, WIDTH=4, back-to-back requests -> exactly 1 frame_valid=0 cycle between 4-bit frames.

Source files
------------

// File: rtl/siso_ctrl_pkg.sv
// Shared types and helpers for the two-requester serial transmit arbiter.
package siso_ctrl_pkg;

   // State encodings, kept explicit so waveforms decode the same everywhere.
   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_SHIFT_ENC = 2'd1;
   localparam logic [1:0] ST_GAP_ENC   = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE_ENC,
      SHIFT = ST_SHIFT_ENC,
      GAP   = ST_GAP_ENC
   } tx_state_t;

   // Width of the inter-frame gap counter; never narrower than one bit so
   // the register still exists when no gap is configured.
   function automatic int gap_cnt_width(input int gap_cycles);
      int w;
      w = $clog2(gap_cycles + 1);
      return (w < 1) ? 1 : w;
   endfunction

   // Round-robin pick: a lone requester wins outright; on a tie the side
   // that did not win last time gets the link. Returns the winning index.
   function automatic logic rr_pick(input logic req0, input logic req1,
                                    input logic rr_last);
      if (req0 && req1) begin
         return ~rr_last;
      end
      return req1;
   endfunction

endpackage

// File: rtl/siso_arb_tx_if.sv
// Producer-side bundle of the serial transmit arbiter: two request/data
// pairs in, grants and the serial link status out.
interface siso_arb_tx_if #(
   parameter int WIDTH = 8
);
   logic             req0;
   logic [WIDTH-1:0] data0;
   logic             req1;
   logic [WIDTH-1:0] data1;
   logic             gnt0;
   logic             gnt1;
   logic             serial_out;
   logic             frame_valid;
   logic             frame_last;
   logic             src_id;
   logic             busy;

   // Producers / environment side.
   modport master (
      output req0, data0, req1, data1,
      input  gnt0, gnt1, serial_out, frame_valid, frame_last, src_id, busy
   );

   // Arbiter side.
   modport slave (
      input  req0, data0, req1, data1,
      output gnt0, gnt1, serial_out, frame_valid, frame_last, src_id, busy
   );
endinterface

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter. A load presents the MSB on the next cycle;
// each shift_en presents the following bit; otherwise the output rests at 0.
module piso_shifter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             load,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] data_in,
   output logic             serial_out
);

   // shift_reg holds the bits not yet presented, left-aligned.
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shifted;
   logic             out_reg;

   // Move every remaining bit one place toward the MSB, zero-filling.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (gi == 0) begin : g_lsb
            assign shifted[gi] = 1'b0;
         end else begin : g_bit
            assign shifted[gi] = shift_reg[gi-1];
         end
      end
   endgenerate

   // Load, shift, or park the output low between frames.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         shift_reg <= '0;
         out_reg   <= 1'b0;
      end else if (load) begin
         out_reg   <= data_in[WIDTH-1];
         shift_reg <= {data_in[WIDTH-2:0], 1'b0};
      end else if (shift_en) begin
         out_reg   <= shift_reg[WIDTH-1];
         shift_reg <= shifted;
      end else begin
         out_reg   <= 1'b0;
      end
   end

   assign serial_out = out_reg;

endmodule

// File: rtl/siso_arb_tx.sv
// Two-requester round-robin arbiter feeding a shared serial link. A granted
// word goes out MSB-first over WIDTH cycles, followed by a forced idle gap.
module siso_arb_tx
   import siso_ctrl_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic         clk,
   input  logic         Rst,
   siso_arb_tx_if.slave bus
);

   localparam int              CW       = $clog2(WIDTH);
   localparam int              GW       = gap_cnt_width(GAP_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
   localparam logic [GW-1:0]   GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   tx_state_t        state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [GW-1:0]    gap_reg, gap_next;
   logic             rr_last_reg, rr_last_next;
   logic             src_id_reg, src_id_next;
   logic             gnt0_reg, gnt0_next;
   logic             gnt1_reg, gnt1_next;
   logic             fv_reg, fv_next;
   logic             fl_reg, fl_next;
   logic             busy_reg, busy_next;

   logic             winner;
   logic             load;
   logic             shift_en;
   logic [WIDTH-1:0] load_word;

   assign winner    = rr_pick(bus.req0, bus.req1, rr_last_reg);
   assign load_word = winner ? bus.data1 : bus.data0;

   // Next-state, counters and the registered status outputs. Status is
   // derived from where the FSM is going so it lines up with the shifter.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      gap_next     = gap_reg;
      rr_last_next = rr_last_reg;
      src_id_next  = src_id_reg;
      load         = 1'b0;
      shift_en     = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               load         = 1'b1;
               rr_last_next = winner;
               src_id_next  = winner;
               cnt_next     = '0;
               state_next   = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_reg == CNT_LAST) begin
               gap_next   = '0;
               state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
            end else begin
               shift_en = 1'b1;
               cnt_next = cnt_reg + 1'b1;
            end
         end
         GAP: begin
            if (gap_reg == GAP_LAST) begin
               state_next = IDLE;
            end else begin
               gap_next = gap_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      gnt0_next = load && !winner;
      gnt1_next = load && winner;
      fv_next   = (state_next == SHIFT);
      fl_next   = (state_next == SHIFT) && (cnt_next == CNT_LAST);
      busy_next = (state_next != IDLE);
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge Rst) begin
      if (!Rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         gap_reg     <= '0;
         rr_last_reg <= 1'b1;
         src_id_reg  <= 1'b0;
         gnt0_reg    <= 1'b0;
         gnt1_reg    <= 1'b0;
         fv_reg      <= 1'b0;
         fl_reg      <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         gap_reg     <= gap_next;
         rr_last_reg <= rr_last_next;
         src_id_reg  <= src_id_next;
         gnt0_reg    <= gnt0_next;
         gnt1_reg    <= gnt1_next;
         fv_reg      <= fv_next;
         fl_reg      <= fl_next;
         busy_reg    <= busy_next;
      end
   end

   piso_shifter #(
      .WIDTH(WIDTH)
   ) u_shifter (
      .clk       (clk),
      .Rst       (Rst),
      .load      (load),
      .shift_en  (shift_en),
      .data_in   (load_word),
      .serial_out(bus.serial_out)
   );

   assign bus.gnt0        = gnt0_reg;
   assign bus.gnt1        = gnt1_reg;
   assign bus.frame_valid = fv_reg;
   assign bus.frame_last  = fl_reg;
   assign bus.src_id      = src_id_reg;
   assign bus.busy        = busy_reg;

endmodule
